// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter sharing one combinational adder_subtractor
// among N requesters.
//   CLK, RST            clock, synchronous active-high reset
//   REQ/ACK             per-requester request, one-cycle one-hot grant acknowledge
//   A_IN/B_IN/SUB_IN/U_IN  packed per-requester operands, requester k at [k*W +: W]
//   A/B/SUB/U           registered operands to the shared unit
//   S/V                 result from the shared unit
//   RES_VALID/RES_READY result handshake; RES_ID/RES_S/RES_V result payload
//   OVF_CNT             overflow statistics, present only with ADDSUB_ARB_STATS_EN
module addsub_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         REQ,
    input  logic [N*W-1:0]       A_IN,
    input  logic [N*W-1:0]       B_IN,
    input  logic [N-1:0]         SUB_IN,
    input  logic [N-1:0]         U_IN,
    output logic [N-1:0]         ACK,
    output logic [W-1:0]         A,
    output logic [W-1:0]         B,
    output logic                 SUB,
    output logic                 U,
    input  logic [W-1:0]         S,
    input  logic                 V,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [$clog2(N)-1:0] RES_ID,
    output logic [W-1:0]         RES_S,
    output logic                 RES_V
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [7:0]           OVF_CNT
`endif
);

    localparam int unsigned IDW = $clog2(N);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] owner, owner_n;
    logic [IDW-1:0] gnt;
    logic           gnt_vld;
    logic [IDW:0]   sum;
    logic [IDW:0]   gnt_inc;
    logic [N-1:0]   ack_n;
    logic [W-1:0]   a_n, b_n, s_n;
    logic           sub_n, u_n, valid_n, v_n;
    logic [IDW-1:0] id_n;

    // Rotating-priority search: first set REQ bit starting at ptr, wrapping mod N.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(N)) begin
                sum = sum - (IDW+1)'(N);
            end
            if (!gnt_vld && REQ[sum[IDW-1:0]]) begin
                gnt     = sum[IDW-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        ack_n   = '0;
        a_n     = A;
        b_n     = B;
        sub_n   = SUB;
        u_n     = U;
        valid_n = RES_VALID;
        id_n    = RES_ID;
        s_n     = RES_S;
        v_n     = RES_V;
        gnt_inc = {1'b0, gnt} + (IDW+1)'(1);
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    a_n         = A_IN[32'(gnt)*W +: W];
                    b_n         = B_IN[32'(gnt)*W +: W];
                    sub_n       = SUB_IN[gnt];
                    u_n         = U_IN[gnt];
                    ack_n[gnt]  = 1'b1;
                    owner_n     = gnt;
                    ptr_n       = (gnt_inc == (IDW+1)'(N)) ? '0 : gnt_inc[IDW-1:0];
                    state_n     = EXEC;
                end
            end
            EXEC: begin
                // Shared unit has had a full cycle on the registered operands.
                s_n     = S;
                v_n     = V;
                id_n    = owner;
                valid_n = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                if (RES_READY) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            ACK       <= '0;
            A         <= '0;
            B         <= '0;
            SUB       <= 1'b0;
            U         <= 1'b0;
            RES_VALID <= 1'b0;
            RES_ID    <= '0;
            RES_S     <= '0;
            RES_V     <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            ACK       <= ack_n;
            A         <= a_n;
            B         <= b_n;
            SUB       <= sub_n;
            U         <= u_n;
            RES_VALID <= valid_n;
            RES_ID    <= id_n;
            RES_S     <= s_n;
            RES_V     <= v_n;
        end
    end

`ifdef ADDSUB_ARB_STATS_EN
    // Saturating count of accepted results that flagged carry/borrow/overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVF_CNT <= '0;
        end else if (RES_VALID && RES_READY && RES_V && (OVF_CNT != 8'hFF)) begin
            OVF_CNT <= OVF_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter (N=4, W=4) with a behavioural model
// of the arbitration timeline and of the shared adder_subtractor.
module tb_addsub_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 4;
    localparam int unsigned IDW = 2;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] A_IN, B_IN;
    logic [N-1:0]   SUB_IN, U_IN;
    logic [N-1:0]   ACK;
    logic [W-1:0]   A, B, S;
    logic           SUB, U, V;
    logic           RES_VALID, RES_READY, RES_V;
    logic [IDW-1:0] RES_ID;
    logic [W-1:0]   RES_S;
`ifdef ADDSUB_ARB_STATS_EN
    logic [7:0]     OVF_CNT;
`endif

    int errors = 0;
    int checks = 0;

    addsub_arbiter #(.N(N), .W(W)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
        .SUB_IN(SUB_IN), .U_IN(U_IN), .ACK(ACK), .A(A), .B(B), .SUB(SUB), .U(U),
        .S(S), .V(V), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_ID(RES_ID), .RES_S(RES_S), .RES_V(RES_V)
`ifdef ADDSUB_ARB_STATS_EN
        , .OVF_CNT(OVF_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Arithmetic reference of the shared unit: returns {V, S}.
    function automatic logic [W:0] au(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub, input logic u);
        int ai, bi, r;
        logic v;
        if (u) begin
            ai = int'(a);
            bi = int'(b);
        end else begin
            ai = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
            bi = (int'(b) >= 8) ? int'(b) - 16 : int'(b);
        end
        r = sub ? ai - bi : ai + bi;
        if (u) v = (r < 0) || (r > 15);
        else   v = (r < -8) || (r > 7);
        return {v, W'(r)};
    endfunction

    // The shared adder_subtractor sitting behind the arbiter.
    always_comb {V, S} = au(A, B, SUB, U);

    // Behavioural model: expected outputs after the next edge.
    logic [N-1:0] m_ack   = '0;
    logic         m_valid = 1'b0;
    int           m_id    = 0;
    logic [W-1:0] m_s     = '0;
    logic         m_v     = 1'b0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    logic         m_sub   = 1'b0;
    logic         m_u     = 1'b0;
    int           m_ptr   = 0;
    int           m_phase = 0;   // 0 free, 1 computing, 2 awaiting consumer
    int           m_owner = 0;
    int           m_cnt   = 0;

    task automatic model_step();
        int g;
        if (RST) begin
            m_ack = '0; m_valid = 0; m_id = 0; m_s = '0; m_v = 0;
            m_a = '0; m_b = '0; m_sub = 0; m_u = 0;
            m_ptr = 0; m_phase = 0; m_owner = 0; m_cnt = 0;
            return;
        end
        if (m_valid && RES_READY && m_v && m_cnt < 255) m_cnt++;
        m_ack = '0;
        case (m_phase)
            0: begin
                g = -1;
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && REQ[(m_ptr + i) % N]) g = (m_ptr + i) % N;
                end
                if (g >= 0) begin
                    m_ack[g] = 1'b1;
                    m_ptr    = (g + 1) % N;
                    m_a      = A_IN[g*W +: W];
                    m_b      = B_IN[g*W +: W];
                    m_sub    = SUB_IN[g];
                    m_u      = U_IN[g];
                    m_owner  = g;
                    m_phase  = 1;
                end
            end
            1: begin
                {m_v, m_s} = au(m_a, m_b, m_sub, m_u);
                m_id    = m_owner;
                m_valid = 1'b1;
                m_phase = 2;
            end
            default: begin
                if (RES_READY) begin
                    m_valid = 1'b0;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("ack", 32'(ACK), 32'(m_ack));
        chk("res_valid", 32'(RES_VALID), 32'(m_valid));
        chk("res_id", 32'(RES_ID), 32'(m_id));
        chk("res_s", 32'(RES_S), 32'(m_s));
        chk("res_v", 32'(RES_V), 32'(m_v));
        chk("opnd", {22'd0, A, B, SUB, U}, {22'd0, m_a, m_b, m_sub, m_u});
`ifdef ADDSUB_ARB_STATS_EN
        chk("ovf_cnt", 32'(OVF_CNT), 32'(m_cnt));
`endif
    endtask

    // Inputs are already set; predict the edge, then sample on the falling edge.
    task automatic advance();
        model_step();
        @(negedge CLK);
        compare();
    endtask

    task automatic set_op(input int k, input int a, input int b, input bit sub, input bit u);
        A_IN[k*W +: W] = W'(a);
        B_IN[k*W +: W] = W'(b);
        SUB_IN[k]      = sub;
        U_IN[k]        = u;
    endtask

    // Single operation from an idle arbiter, with literal result and latency checks.
    task automatic directed(input int k, input int a, input int b, input bit sub, input bit u,
                            input int es, input int ev);
        int ack_at, val_at;
        ack_at = -1;
        val_at = -1;
        set_op(k, a, b, sub, u);
        REQ[k]    = 1'b1;
        RES_READY = 1'b1;
        for (int c = 1; c <= 8 && val_at < 0; c++) begin
            advance();
            if (ACK == N'(1 << k) && ack_at < 0) ack_at = c;
            if (m_ack[k]) REQ[k] = 1'b0;
            if (RES_VALID && val_at < 0) begin
                val_at = c;
                chk("dir_id", 32'(RES_ID), 32'(k));
                chk("dir_s", 32'(RES_S), 32'(es));
                chk("dir_v", 32'(RES_V), 32'(ev));
            end
        end
        chk("dir_ack_latency", 32'(ack_at), 32'(1));
        chk("dir_valid_latency", 32'(val_at), 32'(2));
        REQ[k] = 1'b0;
        advance();
    endtask

    // All four requesters asserted together; check grant order and spacing.
    task automatic rr_burst(input int e0, input int e1, input int e2, input int e3);
        int order[$];
        int times[$];
        int exp_o[4];
        exp_o = '{e0, e1, e2, e3};
        REQ       = '1;
        RES_READY = 1'b1;
        for (int c = 1; c <= 30 && order.size() < 4; c++) begin
            advance();
            for (int k = 0; k < N; k++) begin
                if (ACK[k]) begin
                    order.push_back(k);
                    times.push_back(c);
                end
            end
            REQ = REQ & ~m_ack;
        end
        chk("rr_count", 32'(order.size()), 32'(4));
        for (int i = 0; i < order.size() && i < 4; i++) begin
            chk("rr_order", 32'(order[i]), 32'(exp_o[i]));
            if (i > 0) chk("rr_spacing", 32'(times[i] - times[i-1]), 32'(3));
        end
        REQ = '0;
        advance();
        advance();
    endtask

    initial begin
        int vld_seen;
        RST = 1'b1; REQ = '0; A_IN = '0; B_IN = '0; SUB_IN = '0; U_IN = '0; RES_READY = 1'b0;
        advance();
        advance();
        chk("reset_ack", 32'(ACK), 32'(0));
        chk("reset_valid", 32'(RES_VALID), 32'(0));
        chk("reset_res", {25'd0, RES_ID, RES_S, RES_V}, 32'(0));
        chk("reset_opnd", {22'd0, A, B, SUB, U}, 32'(0));
        RST = 1'b0;
        advance();

        // Basic add plus the unsigned/signed carry and overflow corners.
        directed(1, 7, 5, 0, 1, 12, 0);
        directed(0, 3, 5, 1, 1, 14, 1);
        directed(2, 7, 1, 0, 0, 8, 1);
        directed(3, 8, 1, 1, 0, 7, 1);

        // Round robin from pointer 0, then from pointer 2.
        rr_burst(0, 1, 2, 3);
        directed(1, 2, 3, 0, 1, 5, 0);
        rr_burst(2, 3, 0, 1);

        // Consumer stalls while another request waits.
        set_op(0, 1, 1, 0, 1);
        REQ = 4'b0001;
        RES_READY = 1'b0;
        vld_seen = 0;
        for (int c = 0; c < 6 && !vld_seen; c++) begin
            advance();
            if (m_ack[0]) REQ[0] = 1'b0;
            if (RES_VALID) vld_seen = 1;
        end
        chk("stall_valid_seen", 32'(vld_seen), 32'(1));
        set_op(2, 9, 4, 1, 1);
        REQ[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            advance();
            chk("stall_no_ack", 32'(ACK), 32'(0));
            chk("stall_hold", {26'd0, RES_VALID, RES_ID, RES_S}, {26'd0, 1'b1, 2'd0, 4'd2});
        end
        RES_READY = 1'b1;
        advance();
        chk("release_valid_low", 32'(RES_VALID), 32'(0));
        chk("release_no_ack_yet", 32'(ACK), 32'(0));
        advance();
        chk("release_ack", 32'(ACK), 32'(4'b0100));
        REQ[2] = 1'b0;
        advance();
        chk("release_res_s", 32'(RES_S), 32'(5));
        advance();

        // Reset while computing discards the operation.
        set_op(0, 4, 4, 0, 1);
        REQ = 4'b0001;
        advance();
        chk("pre_rst_ack", 32'(ACK), 32'(4'b0001));
        REQ = '0;
        RST = 1'b1;
        advance();
        chk("rst_exec_valid", 32'(RES_VALID), 32'(0));
        chk("rst_exec_ack", 32'(ACK), 32'(0));
        chk("rst_exec_res", {25'd0, RES_ID, RES_S, RES_V}, 32'(0));
        chk("rst_exec_opnd", {22'd0, A, B, SUB, U}, 32'(0));
        RST = 1'b0;
        REQ = '1;
        advance();
        chk("rst_first_grant", 32'(ACK), 32'(4'b0001));

        // Randomized traffic with withdrawals, stalls and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < N; k++) begin
                if (REQ[k] && m_ack[k]) begin
                    REQ[k] = 1'b0;
                end else if (REQ[k]) begin
                    if ($urandom_range(0, 39) == 0) REQ[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    set_op(k, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    REQ[k] = 1'b1;
                end
            end
            RES_READY = ($urandom_range(0, 9) < 7);
            advance();
        end
        RST = 1'b0;
        REQ = '0;
        RES_READY = 1'b1;
        for (int c = 0; c < 5; c++) advance();

`ifdef ADDSUB_ARB_STATS_EN
        RST = 1'b1;
        advance();
        RST = 1'b0;
        advance();
        for (int i = 0; i < 3; i++) directed(0, 0, 1, 1, 1, 15, 1);
        for (int i = 0; i < 2; i++) directed(0, 1, 1, 0, 1, 2, 0);
        chk("ovf_cnt_3", 32'(OVF_CNT), 32'(3));
        for (int i = 0; i < 300; i++) directed(0, 15, 1, 0, 1, 0, 1);
        chk("ovf_cnt_sat", 32'(OVF_CNT), 32'(255));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
